// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU constants for the common data bus arbiter.
// Holds the default ROB tag width, producer count and round-robin helper.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_WIDTH_DEF = 4;
    localparam int unsigned NUM_PROD      = 4;
    localparam int unsigned DATA_WIDTH    = 32;

    // Round-robin index advance; the 2-bit width wraps modulo the producer count.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker over four pending slots.
// Returns one-hot grants for bus 0 and bus 1 plus the index of the last grant.
module rr_pick2
    import cdb_arbiter_pkg::*;
(
    input  logic [3:0] pend,
    input  logic [1:0] rr,
    output logic [3:0] grant0,
    output logic [3:0] grant1,
    output logic [1:0] last_idx,
    output logic       any_grant
);

    logic [1:0] idx;

    always_comb begin
        grant0    = '0;
        grant1    = '0;
        last_idx  = rr;
        any_grant = 1'b0;
        idx       = rr;
        for (int k = 0; k < 4; k++) begin
            if (pend[idx]) begin
                if (!any_grant) begin
                    grant0[idx] = 1'b1;
                    any_grant   = 1'b1;
                    last_idx    = idx;
                end else if (grant1 == 4'b0000) begin
                    grant1[idx] = 1'b1;
                    last_idx    = idx;
                end
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers one result per producer and broadcasts up
// to two per cycle on cdb0/cdb1 in round-robin order.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int unsigned NUM_REQ   = NUM_PROD
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            clear_signal,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_value,
    input  logic [NUM_REQ*ROB_WIDTH-1:0]    req_tag,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            cdb0_done,
    output logic [DATA_WIDTH-1:0]           cdb0_value,
    output logic [ROB_WIDTH-1:0]            cdb0_tag,
    output logic                            cdb1_done,
    output logic [DATA_WIDTH-1:0]           cdb1_value,
    output logic [ROB_WIDTH-1:0]            cdb1_tag
);

    logic [NUM_REQ-1:0]    pend_q, pend_d;
    logic [DATA_WIDTH-1:0] val_q [NUM_REQ];
    logic [DATA_WIDTH-1:0] val_d [NUM_REQ];
    logic [ROB_WIDTH-1:0]  tag_q [NUM_REQ];
    logic [ROB_WIDTH-1:0]  tag_d [NUM_REQ];
    logic [1:0]            rr_q, rr_d;

    logic                  cdb0_done_d, cdb1_done_d;
    logic [DATA_WIDTH-1:0] cdb0_value_d, cdb1_value_d;
    logic [ROB_WIDTH-1:0]  cdb0_tag_d, cdb1_tag_d;

    logic [3:0]            grant0, grant1;
    logic [NUM_REQ-1:0]    grant, accept;
    logic [1:0]            last_idx;
    logic                  any_grant;

    rr_pick2 u_pick (
        .pend      (pend_q),
        .rr        (rr_q),
        .grant0    (grant0),
        .grant1    (grant1),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    assign grant     = grant0 | grant1;
    // A granted slot drains this edge, so it can take a new result at the same time.
    assign req_ready = {NUM_REQ{~rst_in & rdy_in & ~clear_signal}} & (~pend_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        pend_d       = pend_q;
        val_d        = val_q;
        tag_d        = tag_q;
        rr_d         = rr_q;
        cdb0_done_d  = 1'b0;
        cdb1_done_d  = 1'b0;
        cdb0_value_d = '0;
        cdb1_value_d = '0;
        cdb0_tag_d   = '0;
        cdb1_tag_d   = '0;

        // One-hot AND-OR muxes from the pending slots onto each bus.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant0[i]) begin
                cdb0_value_d = cdb0_value_d | val_q[i];
                cdb0_tag_d   = cdb0_tag_d | tag_q[i];
            end
            if (grant1[i]) begin
                cdb1_value_d = cdb1_value_d | val_q[i];
                cdb1_tag_d   = cdb1_tag_d | tag_q[i];
            end
        end

        if (clear_signal) begin
            pend_d = '0;
            rr_d   = 2'd0;
        end else begin
            cdb0_done_d = |grant0;
            cdb1_done_d = |grant1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    pend_d[i] = 1'b1;
                    val_d[i]  = req_value[i*DATA_WIDTH +: DATA_WIDTH];
                    tag_d[i]  = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
                end else if (grant[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
            if (any_grant) begin
                rr_d = rr_next(last_idx);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q     <= '0;
            rr_q       <= 2'd0;
            cdb0_done  <= 1'b0;
            cdb1_done  <= 1'b0;
            cdb0_value <= '0;
            cdb1_value <= '0;
            cdb0_tag   <= '0;
            cdb1_tag   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            cdb0_done  <= cdb0_done_d;
            cdb1_done  <= cdb1_done_d;
            // On flush the bus data is left as-is; only the done bits matter.
            if (!clear_signal) begin
                cdb0_value <= cdb0_value_d;
                cdb1_value <= cdb1_value_d;
                cdb0_tag   <= cdb0_tag_d;
                cdb1_tag   <= cdb1_tag_d;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule
